dcmi_cam_tx: RTL and testbench



---
 rtl/dcmi_cam_tx_if.sv | 12 +
 rtl/dcmi_cam_tx.sv | 93 +++++++++
 tb/tb_dcmi_cam_tx.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dcmi_cam_tx_if.sv
// dcmi_cam_tx_if: upstream pixel stream plus the DCMI camera-side bus.
// master is the camera emulator; slave is whoever feeds pixels and captures the bus.
interface dcmi_cam_tx_if;
    logic        PIX_VALID;
    logic [11:0] PIX_DATA;
    logic        PIX_READY;
    logic        CAM_VSYNC;
    logic        CAM_HREF;
    logic [7:0]  CAM_D;
    modport master (input PIX_VALID, PIX_DATA, output PIX_READY, CAM_VSYNC, CAM_HREF, CAM_D);
    modport slave (output PIX_VALID, PIX_DATA, input PIX_READY, CAM_VSYNC, CAM_HREF, CAM_D);
endinterface

// File: rtl/dcmi_cam_tx.sv
// dcmi_cam_tx: camera-side DCMI source emitting VSYNC/HREF timing and RGB444 byte pairs.
// Counters track the cycle being presented; all bus outputs are registered from next-cycle values.
module dcmi_cam_tx #(
    parameter int H_ACTIVE = 320,
    parameter int H_BLANK  = 64,
    parameter int V_ACTIVE = 240,
    parameter int VS_WIDTH = 3,
    parameter int V_BP     = 17,
    parameter int V_FP     = 10
) (
    input  logic          PCLK,
    input  logic          RESET,
    input  logic          EN,
    input  logic [1:0]    PATTERN_MODE,
    input  logic          UNDERRUN_CLR,
    output logic          FRAME_START,
    output logic          FRAME_DONE,
    output logic          UNDERRUN,
    dcmi_cam_tx_if.master bus
);
    localparam int LINE_LEN = 2 * H_ACTIVE + H_BLANK;
    localparam int HW = LINE_LEN > 1 ? $clog2(LINE_LEN) : 1;
    localparam int M1 = VS_WIDTH > V_BP ? VS_WIDTH : V_BP;
    localparam int M2 = V_ACTIVE > V_FP ? V_ACTIVE : V_FP;
    localparam int L_MAX = M1 > M2 ? M1 : M2;
    localparam int LW = L_MAX > 1 ? $clog2(L_MAX) : 1;
    localparam logic [11:0] BARS [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
    typedef enum logic [2:0] {IDLE, VSYNC, VBP, ACTIVE, VFP} state_t;
    state_t        state, nxt_state;
    logic [HW-1:0] h_cnt, nxt_h;
    logic [LW-1:0] l_cnt, nxt_l;
    logic [1:0]    mode;
    logic [11:0]   pix_reg, pix;
    logic [31:0]   phase_len, x32;
    logic [2:0]    bar;
    logic          line_end, phase_end, href_nxt, fetch, start, done, und_set;
    always_comb begin
        line_end = 32'(h_cnt) == 32'(LINE_LEN - 1);
        phase_len = state == VSYNC ? 32'(VS_WIDTH) : state == VBP ? 32'(V_BP) :
                    state == ACTIVE ? 32'(V_ACTIVE) : 32'(V_FP);
        phase_end = line_end && 32'(l_cnt) == phase_len - 32'd1;
        nxt_state = state;
        nxt_h = '0;
        nxt_l = '0;
        if (state == IDLE) nxt_state = EN ? VSYNC : IDLE;
        else begin
            nxt_h = line_end ? '0 : h_cnt + 1'b1;
            nxt_l = phase_end ? '0 : line_end ? l_cnt + 1'b1 : l_cnt;
            if (phase_end)
                nxt_state = state == VSYNC ? VBP : state == VBP ? ACTIVE : state == ACTIVE ? VFP : EN ? VSYNC : IDLE;
        end
        // the pixel fetch happens in the cycle before its even byte appears on CAM_D
        href_nxt = nxt_state == ACTIVE && 32'(nxt_h) < 32'(2 * H_ACTIVE);
        fetch = href_nxt && !nxt_h[0];
        x32 = 32'(nxt_h) >> 1;
        bar = 3'((x32 * 32'd8) / 32'(H_ACTIVE));
        pix = mode == 2'd0 ? (bus.PIX_VALID ? bus.PIX_DATA : 12'h000) :
              mode == 2'd1 ? BARS[bar] :
              mode == 2'd2 ? {4'(nxt_l), 8'(x32)} : 12'h000;
        bus.PIX_READY = fetch && mode == 2'd0 && !RESET;
        und_set = bus.PIX_READY && !bus.PIX_VALID;
        start = nxt_state == VSYNC && state != VSYNC;
        done = nxt_state == VFP && 32'(nxt_l) == 32'(V_FP - 1) && 32'(nxt_h) == 32'(LINE_LEN - 1);
    end
    always_ff @(posedge PCLK) begin
        if (RESET) begin
            state <= IDLE;
            h_cnt <= '0;
            l_cnt <= '0;
            mode <= '0;
            pix_reg <= '0;
            bus.CAM_VSYNC <= 1'b0;
            bus.CAM_HREF <= 1'b0;
            bus.CAM_D <= 8'h00;
            FRAME_START <= 1'b0;
            FRAME_DONE <= 1'b0;
            UNDERRUN <= 1'b0;
        end else begin
            state <= nxt_state;
            h_cnt <= nxt_h;
            l_cnt <= nxt_l;
            if (start) mode <= PATTERN_MODE;
            if (fetch) pix_reg <= pix;
            bus.CAM_VSYNC <= nxt_state == VSYNC;
            bus.CAM_HREF <= href_nxt;
            bus.CAM_D <= fetch ? {1'b0, pix[11:8], 2'b00, pix[7]} :
                         href_nxt ? {pix_reg[6:4], 1'b0, pix_reg[3:0]} : 8'h00;
            FRAME_START <= start;
            FRAME_DONE <= done;
            UNDERRUN <= und_set || (UNDERRUN && !UNDERRUN_CLR);
        end
    end
endmodule

// File: tb/tb_dcmi_cam_tx.sv
// tb_dcmi_cam_tx: scoreboard bench for the DCMI camera emulator on a small 10x5-line frame.
// A second instance with H_ACTIVE=8 covers the eight colour bars.
`timescale 1ns/1ps
module tb_dcmi_cam_tx;
    logic        clk = 1'b0;
    logic        RESET = 1'b1;
    logic        EN = 1'b0;
    logic        UNDERRUN_CLR = 1'b0;
    logic [1:0]  PATTERN_MODE = 2'd0;
    logic        FRAME_START, FRAME_DONE, UNDERRUN, fs8, fd8, und8;
    int          pass_cnt = 0, total = 0;
    logic [7:0]  exp_q[$], got_q[$];
    logic [11:0] pix_q[$];
    int          xfers, fd_at, fd_n, href_bad, d_bad;
    dcmi_cam_tx_if bus();
    dcmi_cam_tx_if bus8();
    always #5 clk = ~clk;
    dcmi_cam_tx #(.H_ACTIVE(4), .H_BLANK(2), .V_ACTIVE(2), .VS_WIDTH(1), .V_BP(1), .V_FP(1)) dut (
        .PCLK(clk), .RESET(RESET), .EN(EN), .PATTERN_MODE(PATTERN_MODE), .UNDERRUN_CLR(UNDERRUN_CLR),
        .FRAME_START(FRAME_START), .FRAME_DONE(FRAME_DONE), .UNDERRUN(UNDERRUN), .bus(bus));
    dcmi_cam_tx #(.H_ACTIVE(8), .H_BLANK(2), .V_ACTIVE(2), .VS_WIDTH(1), .V_BP(1), .V_FP(1)) dut8 (
        .PCLK(clk), .RESET(RESET), .EN(EN), .PATTERN_MODE(PATTERN_MODE), .UNDERRUN_CLR(1'b0),
        .FRAME_START(fs8), .FRAME_DONE(fd8), .UNDERRUN(und8), .bus(bus8));

    function automatic logic [7:0] ev(input logic [11:0] p);
        return {1'b0, p[11:8], 2'b00, p[7]};
    endfunction
    function automatic logic [7:0] od(input logic [11:0] p);
        return {p[6:4], 1'b0, p[3:0]};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_fs(input bit use8, output bit ok);
        ok = 1'b0;
        for (int i = 0; i < 200 && !ok; i++) begin
            step();
            ok = use8 ? fs8 : FRAME_START;
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        xfers = 0; fd_at = -1; fd_n = 0; href_bad = 0; d_bad = 0;
    endtask

    // walks frame cycles c0..c1 of the small instance, recording bytes and events
    task automatic run(input int c0, input int c1, input int drop);
        for (int c = c0; c <= c1; c++) begin
            bus.PIX_VALID = (c != drop);
            #1;
            if ((c >= 20 && c < 40 && c % 10 < 8) != bus.CAM_HREF) href_bad++;
            if (!bus.CAM_HREF && bus.CAM_D != 8'h00) d_bad++;
            if (bus.CAM_HREF) got_q.push_back(bus.CAM_D);
            if (bus.PIX_READY && bus.PIX_VALID) xfers++;
            if (FRAME_DONE) begin fd_at = c; fd_n++; end
            if (c < c1) step();
        end
    endtask

    task automatic test_reset();
        logic seen = 1'b0;
        int cnt = 0;
        RESET = 1'b1; EN = 1'b1; PATTERN_MODE = 2'd0;
        bus.PIX_VALID = 1'b1; bus.PIX_DATA = 12'hABC;
        bus8.PIX_VALID = 1'b0; bus8.PIX_DATA = 12'h000;
        repeat (3) begin step(); seen = seen | FRAME_START; end
        total++;
        if ({bus.CAM_VSYNC, bus.CAM_HREF, bus.CAM_D, FRAME_START, FRAME_DONE, UNDERRUN, bus.PIX_READY} !== 14'h0)
            $display("FAIL reset_outputs got %h want 0",
                     {bus.CAM_VSYNC, bus.CAM_HREF, bus.CAM_D, FRAME_START, FRAME_DONE, UNDERRUN, bus.PIX_READY});
        else pass_cnt++;
        total++;
        if (seen !== 1'b0) $display("FAIL reset_no_fs got %b want 0", seen); else pass_cnt++;
        RESET = 1'b0;
        step();
        total++;
        if ({bus.CAM_VSYNC, FRAME_START} !== 2'b11)
            $display("FAIL reset_release_vs_fs got %b want 11", {bus.CAM_VSYNC, FRAME_START});
        else pass_cnt++;
        while (bus.CAM_VSYNC && cnt < 20) begin cnt++; step(); end
        total++;
        if (cnt != 10) $display("FAIL vsync_width got %0d want 10", cnt); else pass_cnt++;
    endtask

    task automatic test_stream();
        bit ok;
        logic [7:0] e, g;
        bus.PIX_DATA = 12'hABC;
        wait_fs(1'b0, ok);
        total++;
        if (!ok) $display("FAIL stream_fs_timeout got 0 want 1"); else pass_cnt++;
        clear_mon();
        repeat (8) begin exp_q.push_back(8'h51); exp_q.push_back(8'h6C); end
        run(0, 49, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            total++;
            if (g !== e) $display("FAIL stream_byte got %h want %h", g, e); else pass_cnt++;
        end
        total++;
        if (got_q.size() != 0) $display("FAIL stream_extra got %0d want 0", got_q.size()); else pass_cnt++;
        total++;
        if (href_bad != 0 || d_bad != 0) $display("FAIL stream_href_timing got %0d/%0d want 0/0", href_bad, d_bad);
        else pass_cnt++;
        total++;
        if (xfers != 8) $display("FAIL stream_xfers got %0d want 8", xfers); else pass_cnt++;
        total++;
        if (fd_at != 49 || fd_n != 1) $display("FAIL stream_frame_done got c%0d n%0d want c49 n1", fd_at, fd_n);
        else pass_cnt++;
    endtask

    task automatic test_underrun();
        bit ok;
        logic [7:0] e, g;
        wait_fs(1'b0, ok);
        total++;
        if (!ok) $display("FAIL und_fs_timeout got 0 want 1"); else pass_cnt++;
        clear_mon();
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < 4; x++) begin
                exp_q.push_back((l == 0 && x == 2) ? 8'h00 : 8'h51);
                exp_q.push_back((l == 0 && x == 2) ? 8'h00 : 8'h6C);
            end
        run(0, 23, 23);
        total++;
        if (UNDERRUN !== 1'b0) $display("FAIL und_early got %b want 0", UNDERRUN); else pass_cnt++;
        step();
        run(24, 49, 23);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            total++;
            if (g !== e) $display("FAIL und_byte got %h want %h", g, e); else pass_cnt++;
        end
        total++;
        if (UNDERRUN !== 1'b1) $display("FAIL und_set got %b want 1", UNDERRUN); else pass_cnt++;
        wait_fs(1'b0, ok);
        total++;
        if (!ok || UNDERRUN !== 1'b1) $display("FAIL und_sticky got %b want 1", UNDERRUN); else pass_cnt++;
        UNDERRUN_CLR = 1'b1;
        step();
        UNDERRUN_CLR = 1'b0;
        total++;
        if (UNDERRUN !== 1'b0) $display("FAIL und_clear got %b want 0", UNDERRUN); else pass_cnt++;
        run(1, 22, -1);
        step();
        bus.PIX_VALID = 1'b0; UNDERRUN_CLR = 1'b1;
        step();
        bus.PIX_VALID = 1'b1; UNDERRUN_CLR = 1'b0;
        total++;
        if (UNDERRUN !== 1'b1) $display("FAIL und_set_wins got %b want 1", UNDERRUN); else pass_cnt++;
        UNDERRUN_CLR = 1'b1;
        step();
        UNDERRUN_CLR = 1'b0;
        total++;
        if (UNDERRUN !== 1'b0) $display("FAIL und_clear2 got %b want 0", UNDERRUN); else pass_cnt++;
    endtask

    task automatic test_bars();
        bit ok;
        logic [7:0] b [16];
        logic [11:0] e, g;
        int n = 0;
        PATTERN_MODE = 2'd1;
        pix_q = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};
        wait_fs(1'b1, ok);
        total++;
        if (!ok) $display("FAIL bars_fs_timeout got 0 want 1"); else pass_cnt++;
        for (int c = 0; c < 90 && n < 16; c++) begin
            if (bus8.CAM_HREF) begin b[n] = bus8.CAM_D; n++; end
            step();
        end
        total++;
        if (n != 16) $display("FAIL bars_bytes got %0d want 16", n); else pass_cnt++;
        for (int i = 0; i < 8; i++) begin
            e = pix_q.pop_front();
            g = {b[2*i][6:3], b[2*i][0], b[2*i+1][7:5], b[2*i+1][3:0]};
            total++;
            if (g !== e) $display("FAIL bar_%0d got %h want %h", i, g, e); else pass_cnt++;
        end
    endtask

    task automatic test_counter();
        bit ok;
        logic [7:0] e, g;
        logic [11:0] p;
        PATTERN_MODE = 2'd2;
        for (int l = 0; l < 2; l++)
            for (int x = 0; x < 4; x++) begin
                p = {4'(l), 8'(x)};
                exp_q.push_back(ev(p));
                exp_q.push_back(od(p));
            end
        wait_fs(1'b0, ok);
        total++;
        if (!ok) $display("FAIL cnt_fs_timeout got 0 want 1"); else pass_cnt++;
        PATTERN_MODE = 2'd3;
        clear_mon();
        run(0, 49, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            total++;
            if (g !== e) $display("FAIL cnt_byte got %h want %h", g, e); else pass_cnt++;
        end
        total++;
        if (xfers != 0 || UNDERRUN !== 1'b0) $display("FAIL cnt_no_ready got %0d/%b want 0/0", xfers, UNDERRUN);
        else pass_cnt++;
    endtask

    task automatic test_en_drop();
        bit ok;
        logic seen = 1'b0;
        PATTERN_MODE = 2'd0;
        wait_fs(1'b0, ok);
        total++;
        if (!ok) $display("FAIL en_fs_timeout got 0 want 1"); else pass_cnt++;
        clear_mon();
        run(0, 30, -1);
        EN = 1'b0;
        step();
        run(31, 49, -1);
        total++;
        if (got_q.size() != 16 || fd_at != 49) $display("FAIL en_frame_done got b%0d c%0d want b16 c49", got_q.size(), fd_at);
        else pass_cnt++;
        repeat (60) begin step(); seen = seen | bus.CAM_VSYNC | FRAME_START | bus.CAM_HREF; end
        total++;
        if (seen !== 1'b0) $display("FAIL en_idle got %b want 0", seen); else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        bit ok;
        logic [7:0] e, g;
        EN = 1'b1;
        wait_fs(1'b0, ok);
        total++;
        if (!ok) $display("FAIL rst_fs_timeout got 0 want 1"); else pass_cnt++;
        clear_mon();
        run(0, 22, -1);
        total++;
        if (bus.CAM_HREF !== 1'b1) $display("FAIL rst_pre_href got %b want 1", bus.CAM_HREF); else pass_cnt++;
        RESET = 1'b1;
        step();
        total++;
        if ({bus.CAM_VSYNC, bus.CAM_HREF, bus.CAM_D} !== 10'h0)
            $display("FAIL rst_mid_outputs got %h want 0", {bus.CAM_VSYNC, bus.CAM_HREF, bus.CAM_D});
        else pass_cnt++;
        RESET = 1'b0;
        step();
        total++;
        if ({bus.CAM_VSYNC, FRAME_START} !== 2'b11)
            $display("FAIL rst_restart got %b want 11", {bus.CAM_VSYNC, FRAME_START});
        else pass_cnt++;
        clear_mon();
        repeat (8) begin exp_q.push_back(8'h51); exp_q.push_back(8'h6C); end
        run(0, 49, -1);
        while (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            g = got_q.size() > 0 ? got_q.pop_front() : 8'hxx;
            total++;
            if (g !== e) $display("FAIL rst_byte got %h want %h", g, e); else pass_cnt++;
        end
        total++;
        if (fd_at != 49 || href_bad != 0) $display("FAIL rst_frame got c%0d h%0d want c49 h0", fd_at, href_bad);
        else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_stream();
        test_underrun();
        test_bars();
        test_counter();
        test_en_drop();
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1, "watchdog");
    end
endmodule
